wb_commit: RTL and testbench
============================

Name: wb_commit

Overview:
- Write-back commit unit. Consumes the MEM/WB pipeline register outputs and performs the architectural updates for the retiring instruction.
- Owns the HI/LO architectural registers, the LLbit register and a retire counter.
- Drives the GPR-file write port and the CP0 write port.
- Provides registered and bypassed HI/LO/LLbit values to the EX and MEM stages.

Parameters:
- DATA_W, 32, width of GPR, HI, LO and CP0 data.
- GPR_AW, 5, GPR address width.
- CNT_W, 32, retire counter width.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high (`RstEnable = 1'b1`).
- flush  in  1  exception/ERET flush from the pipeline controller.
- wb_gpr_we  in  1  GPR write enable.
- wb_target_gpr  in  GPR_AW  GPR write address.
- wb_exe_result  in  DATA_W  GPR write data.
- wb_hilo_we  in  1  HI/LO write enable.
- wb_hi  in  DATA_W  new HI value.
- wb_lo  in  DATA_W  new LO value.
- wb_llbit_we  in  1  LLbit write enable.
- wb_llbit_value  in  1  new LLbit value.
- wb_cp0_we  in  1  CP0 write enable.
- wb_cp0_waddr  in  5  CP0 register address.
- wb_cp0_wdata  in  DATA_W  CP0 write data.
- rf_we  out  1  GPR-file write enable.
- rf_waddr  out  GPR_AW  GPR-file write address.
- rf_wdata  out  DATA_W  GPR-file write data.
- cp0_we  out  1  CP0 write enable.
- cp0_waddr  out  5  CP0 write address.
- cp0_wdata  out  DATA_W  CP0 write data.
- hi_q  out  DATA_W  architectural HI (registered).
- lo_q  out  DATA_W  architectural LO (registered).
- hi_fwd  out  DATA_W  HI with same-cycle bypass.
- lo_fwd  out  DATA_W  LO with same-cycle bypass.
- llbit_q  out  1  architectural LLbit (registered).
- llbit_fwd  out  1  LLbit with same-cycle bypass.
- retire_cnt  out  CNT_W  count of committing cycles.

Behaviour:
- Reset (rst=1 at clock edge): hi_q=0, lo_q=0, llbit_q=0, retire_cnt=0. Reset overrides every other input.
- GPR port is combinational (0 cycles):
  - rf_we = wb_gpr_we AND (wb_target_gpr != 0). Writes to $0 are suppressed.
  - rf_waddr = wb_target_gpr.
  - rf_wdata = wb_exe_result.
- CP0 port is a combinational pass-through of wb_cp0_we, wb_cp0_waddr and wb_cp0_wdata.
- HI/LO update:
  - If wb_hilo_we=1: hi_q<=wb_hi and lo_q<=wb_lo on the same edge, so both are always updated together.
  - Otherwise hold.
  - flush does NOT affect HI/LO: the retiring instruction is older than the faulting one.
- hi_fwd/lo_fwd = wb_hilo_we ? wb_hi/wb_lo : hi_q/lo_q (combinational).
- LLbit update, priority rst > flush > write:
  - flush=1: llbit_q<=0, even if wb_llbit_we=1 in the same cycle.
  - Else if wb_llbit_we=1: llbit_q<=wb_llbit_value.
  - Else hold.
- llbit_fwd:
  - flush=1: 0.
  - Else wb_llbit_we ? wb_llbit_value : llbit_q.
- Retire counter:
  - Increments by 1 on any edge where (wb_gpr_we | wb_hilo_we | wb_llbit_we | wb_cp0_we) = 1. Bubbles have all enables low and are not counted.
  - Wraps modulo 2^CNT_W; all-ones + 1 = 0.
  - Unaffected by flush.
- Reset asserted mid-stream: the registered state clears on that edge. Combinational outputs keep following the inputs; the MEM/WB register zeroes its enables during reset, so the ports go quiet on the following cycle.
- Latency: architectural state is visible on *_q one cycle after commit and on *_fwd in the commit cycle itself.

Decomposition:
- Shared defines file (existing): `RstEnable`, `ZeroWord`, `NOPRegAddr`, `RegWidth`, `GPR_AddrWidth`, `GPR_DataWidth`. Add `HILO_RESET` (zero) and `LLBIT_RESET` (0).
- One sub-module, hilo_reg: the HI/LO register pair plus its bypass mux, reusable by the EX-stage multiplier/divider tests.
- LLbit logic and the retire counter stay inline.

Test Plan:
- Reset: rst=1 for 2 cycles with all enables and data 0xFFFFFFFF -> hi_q=lo_q=0, llbit_q=0, retire_cnt=0; rf_we=1 (target!=0) combinationally.
- $0 guard: wb_gpr_we=1, wb_target_gpr=0, data 0x12345678 -> rf_we=0; retire_cnt increments by 1. Then target=5 -> rf_we=1, rf_waddr=5.
- HI/LO write: wb_hilo_we=1, wb_hi=0xDEADBEEF, wb_lo=0x00C0FFEE -> hi_fwd/lo_fwd equal these in the same cycle; hi_q/lo_q equal them next cycle; with flush=1 in that cycle they still update.
- LLbit priority: wb_llbit_we=1, value=1 -> llbit_fwd=1, llbit_q=1 next cycle. Then flush=1 with wb_llbit_we=1, value=1 -> llbit_fwd=0, llbit_q=0 next cycle.
- Counter wrap: force retire_cnt to 0xFFFFFFFF, commit one GPR write -> retire_cnt=0x00000000; a bubble (all enables 0) -> no change.
- CP0 pass-through: wb_cp0_we=1, waddr=12, wdata=0x0000FF01 -> cp0_we=1, cp0_waddr=12, cp0_wdata=0x0000FF01 in the same cycle.

Source files
------------

// File: rtl/wb_commit_pkg.sv
// Shared constants and helpers for the write-back commit unit.
// Reset values live here so the HI/LO block and the top agree on them.
package wb_commit_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_GPR_AW = 5;
    localparam int DEF_CNT_W  = 32;
    localparam int CP0_AW     = 5;

    localparam logic             RST_ENABLE   = 1'b1;
    localparam logic             HILO_RESET   = 1'b0;
    localparam logic             LLBIT_RESET  = 1'b0;
    localparam logic [DEF_GPR_AW-1:0] NOP_REG_ADDR = '0;

    // A cycle retires an instruction when any architectural write is requested.
    function automatic logic commit_any(input logic gpr_we, input logic hilo_we,
                                        input logic llbit_we, input logic cp0_we);
        return gpr_we | hilo_we | llbit_we | cp0_we;
    endfunction

endpackage

// File: rtl/wb_commit_if.sv
// MEM/WB-to-commit bundle: retiring-instruction inputs plus the commit unit's
// architectural write ports and bypass outputs.
interface wb_commit_if #(
    parameter int DATA_W = 32,
    parameter int GPR_AW = 5,
    parameter int CNT_W  = 32
);
    logic              flush;
    logic              wb_gpr_we;
    logic [GPR_AW-1:0] wb_target_gpr;
    logic [DATA_W-1:0] wb_exe_result;
    logic              wb_hilo_we;
    logic [DATA_W-1:0] wb_hi;
    logic [DATA_W-1:0] wb_lo;
    logic              wb_llbit_we;
    logic              wb_llbit_value;
    logic              wb_cp0_we;
    logic [4:0]        wb_cp0_waddr;
    logic [DATA_W-1:0] wb_cp0_wdata;

    logic              rf_we;
    logic [GPR_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              cp0_we;
    logic [4:0]        cp0_waddr;
    logic [DATA_W-1:0] cp0_wdata;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] hi_fwd;
    logic [DATA_W-1:0] lo_fwd;
    logic              llbit_q;
    logic              llbit_fwd;
    logic [CNT_W-1:0]  retire_cnt;

    // No handshake: every input is a one-cycle commit request, every output
    // is either combinational on the inputs or state registered on clk.
    modport master (
        output flush, wb_gpr_we, wb_target_gpr, wb_exe_result, wb_hilo_we,
               wb_hi, wb_lo, wb_llbit_we, wb_llbit_value, wb_cp0_we,
               wb_cp0_waddr, wb_cp0_wdata,
        input  rf_we, rf_waddr, rf_wdata, cp0_we, cp0_waddr, cp0_wdata,
               hi_q, lo_q, hi_fwd, lo_fwd, llbit_q, llbit_fwd, retire_cnt
    );

    modport slave (
        input  flush, wb_gpr_we, wb_target_gpr, wb_exe_result, wb_hilo_we,
               wb_hi, wb_lo, wb_llbit_we, wb_llbit_value, wb_cp0_we,
               wb_cp0_waddr, wb_cp0_wdata,
        output rf_we, rf_waddr, rf_wdata, cp0_we, cp0_waddr, cp0_wdata,
               hi_q, lo_q, hi_fwd, lo_fwd, llbit_q, llbit_fwd, retire_cnt
    );

endinterface

// File: rtl/wb_commit_hilo_reg.sv
// HI/LO register pair with same-cycle bypass; both halves always move together.
module hilo_reg
    import wb_commit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_q_o,
    output logic [DATA_W-1:0] lo_q_o,
    output logic [DATA_W-1:0] hi_fwd_o,
    output logic [DATA_W-1:0] lo_fwd_o
);

    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (we_i) begin
            hi_d = hi_i;
            lo_d = lo_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            hi_q <= {DATA_W{HILO_RESET}};
            lo_q <= {DATA_W{HILO_RESET}};
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_q_o   = hi_q;
    assign lo_q_o   = lo_q;
    assign hi_fwd_o = we_i ? hi_i : hi_q;
    assign lo_fwd_o = we_i ? lo_i : lo_q;

endmodule

// File: rtl/wb_commit.sv
// Write-back commit: GPR/CP0 write ports, HI/LO, LLbit and the retire counter.
// Flush only kills LLbit; the retiring instruction is older than the fault.
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int GPR_AW = DEF_GPR_AW,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic      clk,
    input  logic      rst,
    wb_commit_if.slave bus
);

    logic             llbit_q, llbit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             commit;

    assign commit = commit_any(bus.wb_gpr_we, bus.wb_hilo_we,
                               bus.wb_llbit_we, bus.wb_cp0_we);

    // $0 is hardwired to zero, so a write aimed at it never reaches the file.
    assign bus.rf_we    = bus.wb_gpr_we && (bus.wb_target_gpr != GPR_AW'(NOP_REG_ADDR));
    assign bus.rf_waddr = bus.wb_target_gpr;
    assign bus.rf_wdata = bus.wb_exe_result;

    assign bus.cp0_we    = bus.wb_cp0_we;
    assign bus.cp0_waddr = bus.wb_cp0_waddr;
    assign bus.cp0_wdata = bus.wb_cp0_wdata;

    hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo (
        .clk      (clk),
        .rst      (rst),
        .we_i     (bus.wb_hilo_we),
        .hi_i     (bus.wb_hi),
        .lo_i     (bus.wb_lo),
        .hi_q_o   (bus.hi_q),
        .lo_q_o   (bus.lo_q),
        .hi_fwd_o (bus.hi_fwd),
        .lo_fwd_o (bus.lo_fwd)
    );

    always_comb begin
        llbit_d = llbit_q;
        if (bus.flush) begin
            llbit_d = 1'b0;
        end else if (bus.wb_llbit_we) begin
            llbit_d = bus.wb_llbit_value;
        end
    end

    // Natural binary wrap gives the modulo-2^CNT_W behaviour.
    always_comb begin
        cnt_d = cnt_q;
        if (commit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            llbit_q <= LLBIT_RESET;
            cnt_q   <= '0;
        end else begin
            llbit_q <= llbit_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.llbit_q    = llbit_q;
    assign bus.llbit_fwd  = bus.flush ? 1'b0 : (bus.wb_llbit_we ? bus.wb_llbit_value : llbit_q);
    assign bus.retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_commit.sv
// Bench for wb_commit: directed cases then random commits against a reference
// model; a second instance with a 4-bit counter exercises counter wrap.
module tb_wb_commit;

    typedef struct packed {
        logic        rst;
        logic        flush;
        logic        gpr_we;
        logic [4:0]  tgt;
        logic [31:0] res;
        logic        hilo_we;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ll_we;
        logic        ll_v;
        logic        cp0_we;
        logic [4:0]  cp0_a;
        logic [31:0] cp0_d;
    } stim_t;

    typedef struct packed {
        logic        known;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic        cp0_we;
        logic [4:0]  cp0_waddr;
        logic [31:0] cp0_wdata;
        logic [31:0] hi_q;
        logic [31:0] lo_q;
        logic [31:0] hi_fwd;
        logic [31:0] lo_fwd;
        logic        ll_q;
        logic        ll_fwd;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t exp_q[$];

    // reference architectural state
    logic        m_known;
    logic [31:0] m_hi, m_lo, m_cnt;
    logic        m_ll;
    logic [3:0]  m_cnt4;

    wb_commit_if #(.DATA_W(32), .GPR_AW(5), .CNT_W(32)) u_if ();
    wb_commit_if #(.DATA_W(32), .GPR_AW(5), .CNT_W(4))  u_if4 ();

    wb_commit #(.DATA_W(32), .GPR_AW(5), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    wb_commit #(.DATA_W(32), .GPR_AW(5), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (u_if4)
    );

    assign u_if4.flush          = u_if.flush;
    assign u_if4.wb_gpr_we      = u_if.wb_gpr_we;
    assign u_if4.wb_target_gpr  = u_if.wb_target_gpr;
    assign u_if4.wb_exe_result  = u_if.wb_exe_result;
    assign u_if4.wb_hilo_we     = u_if.wb_hilo_we;
    assign u_if4.wb_hi          = u_if.wb_hi;
    assign u_if4.wb_lo          = u_if.wb_lo;
    assign u_if4.wb_llbit_we    = u_if.wb_llbit_we;
    assign u_if4.wb_llbit_value = u_if.wb_llbit_value;
    assign u_if4.wb_cp0_we      = u_if.wb_cp0_we;
    assign u_if4.wb_cp0_waddr   = u_if.wb_cp0_waddr;
    assign u_if4.wb_cp0_wdata   = u_if.wb_cp0_wdata;

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // drive one cycle, push the expected response, then advance the model
    task automatic apply(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        rst                 = s.rst;
        u_if.flush          = s.flush;
        u_if.wb_gpr_we      = s.gpr_we;
        u_if.wb_target_gpr  = s.tgt;
        u_if.wb_exe_result  = s.res;
        u_if.wb_hilo_we     = s.hilo_we;
        u_if.wb_hi          = s.hi;
        u_if.wb_lo          = s.lo;
        u_if.wb_llbit_we    = s.ll_we;
        u_if.wb_llbit_value = s.ll_v;
        u_if.wb_cp0_we      = s.cp0_we;
        u_if.wb_cp0_waddr   = s.cp0_a;
        u_if.wb_cp0_wdata   = s.cp0_d;

        e.known     = m_known;
        e.rf_we     = s.gpr_we && (s.tgt != 5'd0);
        e.rf_waddr  = s.tgt;
        e.rf_wdata  = s.res;
        e.cp0_we    = s.cp0_we;
        e.cp0_waddr = s.cp0_a;
        e.cp0_wdata = s.cp0_d;
        e.hi_q      = m_hi;
        e.lo_q      = m_lo;
        e.hi_fwd    = s.hilo_we ? s.hi : m_hi;
        e.lo_fwd    = s.hilo_we ? s.lo : m_lo;
        e.ll_q      = m_ll;
        e.ll_fwd    = s.flush ? 1'b0 : (s.ll_we ? s.ll_v : m_ll);
        e.cnt       = m_cnt;
        e.cnt4      = m_cnt4;
        exp_q.push_back(e);

        if (s.rst) begin
            m_known = 1'b1;
            m_hi = 32'd0; m_lo = 32'd0; m_ll = 1'b0; m_cnt = 32'd0; m_cnt4 = 4'd0;
        end else begin
            if (s.hilo_we) begin
                m_hi = s.hi;
                m_lo = s.lo;
            end
            if (s.flush) m_ll = 1'b0;
            else if (s.ll_we) m_ll = s.ll_v;
            if (s.gpr_we || s.hilo_we || s.ll_we || s.cp0_we) begin
                m_cnt  = m_cnt + 32'd1;
                m_cnt4 = m_cnt4 + 4'd1;
            end
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rf_we",     32'(u_if.rf_we),     32'(e.rf_we));
            check("rf_waddr",  32'(u_if.rf_waddr),  32'(e.rf_waddr));
            check("rf_wdata",  u_if.rf_wdata,       e.rf_wdata);
            check("cp0_we",    32'(u_if.cp0_we),    32'(e.cp0_we));
            check("cp0_waddr", 32'(u_if.cp0_waddr), 32'(e.cp0_waddr));
            check("cp0_wdata", u_if.cp0_wdata,      e.cp0_wdata);
            if (e.known) begin
                check("hi_q",        u_if.hi_q,              e.hi_q);
                check("lo_q",        u_if.lo_q,              e.lo_q);
                check("hi_fwd",      u_if.hi_fwd,            e.hi_fwd);
                check("lo_fwd",      u_if.lo_fwd,            e.lo_fwd);
                check("llbit_q",     32'(u_if.llbit_q),      32'(e.ll_q));
                check("llbit_fwd",   32'(u_if.llbit_fwd),    32'(e.ll_fwd));
                check("retire_cnt",  u_if.retire_cnt,        e.cnt);
                check("retire_cnt4", 32'(u_if4.retire_cnt),  32'(e.cnt4));
            end
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst     = ($urandom_range(0, 99) < 2);
        s.flush   = ($urandom_range(0, 9) == 0);
        s.gpr_we  = $urandom_range(0, 1) == 1;
        s.tgt     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        s.res     = $urandom;
        s.hilo_we = ($urandom_range(0, 3) == 0);
        s.hi      = $urandom;
        s.lo      = $urandom;
        s.ll_we   = ($urandom_range(0, 3) == 0);
        s.ll_v    = $urandom_range(0, 1) == 1;
        s.cp0_we  = ($urandom_range(0, 3) == 0);
        s.cp0_a   = 5'($urandom_range(0, 31));
        s.cp0_d   = $urandom;
        if ($urandom_range(0, 4) == 0) begin
            s.gpr_we = 1'b0; s.hilo_we = 1'b0; s.ll_we = 1'b0; s.cp0_we = 1'b0;
        end
        return s;
    endfunction

    initial begin
        stim_t s;
        total = 0;
        bad   = 0;
        m_known = 1'b0;
        m_hi = '0; m_lo = '0; m_ll = 1'b0; m_cnt = '0; m_cnt4 = '0;
        rst = 1'b1;
        u_if.flush = 1'b0; u_if.wb_gpr_we = 1'b0; u_if.wb_target_gpr = '0;
        u_if.wb_exe_result = '0; u_if.wb_hilo_we = 1'b0; u_if.wb_hi = '0;
        u_if.wb_lo = '0; u_if.wb_llbit_we = 1'b0; u_if.wb_llbit_value = 1'b0;
        u_if.wb_cp0_we = 1'b0; u_if.wb_cp0_waddr = '0; u_if.wb_cp0_wdata = '0;

        // reset with every input saturated
        s = '1;
        s.rst = 1'b1;
        repeat (2) apply(s);
        apply(idle());

        // $0 guard, then a real target
        s = idle(); s.gpr_we = 1'b1; s.tgt = 5'd0; s.res = 32'h1234_5678;
        apply(s);
        s.tgt = 5'd5;
        apply(s);

        // HI/LO write, then one under flush
        s = idle(); s.hilo_we = 1'b1; s.hi = 32'hDEAD_BEEF; s.lo = 32'h00C0_FFEE;
        apply(s);
        apply(idle());
        s.flush = 1'b1; s.hi = 32'h1111_1111; s.lo = 32'h2222_2222;
        apply(s);
        apply(idle());

        // LLbit set, then flush beats a same-cycle write
        s = idle(); s.ll_we = 1'b1; s.ll_v = 1'b1;
        apply(s);
        apply(idle());
        s.flush = 1'b1;
        apply(s);
        apply(idle());

        // CP0 pass-through
        s = idle(); s.cp0_we = 1'b1; s.cp0_a = 5'd12; s.cp0_d = 32'h0000_FF01;
        apply(s);

        // enough commits to wrap the 4-bit counter, then a bubble
        for (int i = 0; i < 20; i++) begin
            s = idle(); s.gpr_we = 1'b1; s.tgt = 5'($urandom_range(1, 31)); s.res = $urandom;
            apply(s);
        end
        apply(idle());
        apply(idle());

        for (int i = 0; i < 3000; i++) begin
            apply(rand_stim());
        end
        apply(idle());

        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
